clk_en_gen: RTL and testbench
=============================

# clk_en_gen

Multi-channel fractional clock-enable generator. It derives NUM_CH independent clock-enable streams from the single system clock, one phase accumulator per channel. This replaces fixed per-core PLL output taps with runtime-programmable rates, a lock indication and phase re-alignment. It sits directly after the system PLL and drives the CPU, video and audio clock-enable inputs.

## Interface
Parameters:
- NUM_CH, default 3: number of enable channels, 1..8.
- ACC_W, default 16: accumulator width; rate resolution is 1/2^ACC_W of the clk_sys frequency.
- LOCK_CYC, default 16: cycles held unlocked after reset or reconfiguration, 1..65535.
- INC_INIT, default {17'd65536, 17'd8192, 17'd32768}: packed initial increments, NUM_CH×(ACC_W+1) bits, channel 0 in the LSBs.

Ports:
- clk_sys  in  1  system clock, the only clock.
- reset  in  1  synchronous, active-high reset.
- cfg_we  in  1  increment write strobe, one cycle.
- cfg_ch  in  max(1,$clog2(NUM_CH))  target channel of the write.
- cfg_inc  in  ACC_W+1  new increment.
- phase_sync  in  1  pulse that re-aligns all channels.
- ce  out  NUM_CH  per-channel clock enables, single-cycle pulses.
- locked  out  1  high when the enables are valid.

## Operation
- Per channel: inc[i] register (ACC_W+1 bits), acc[i] register (ACC_W bits).
- Increments above 2^ACC_W are clamped to 2^ACC_W on load, both from INC_INIT and from cfg_inc.
- Rate = inc/2^ACC_W × f(clk_sys).
  - inc = 0: ce stays 0.
  - inc = 2^ACC_W: ce is high every cycle.
- Lock FSM has two states, UNLOCK and RUN.
  - UNLOCK: lock counter increments every cycle; acc = 0; ce = 0. When the counter reaches LOCK_CYC−1, the next state is RUN.
  - RUN: each edge computes {carry, acc[i]} <= acc[i] + inc[i], and ce[i] <= carry.
  - Any valid write: go to UNLOCK and clear the counter.
- Valid write: cfg_we=1 with cfg_ch < NUM_CH.
  - inc[cfg_ch] is updated.
  - All acc and ce are cleared.
  - locked is 0 from the next edge.
- A write with cfg_ch ≥ NUM_CH is ignored completely: no state change.
- phase_sync in RUN: all acc and ce are cleared on that edge; locked is unaffected. phase_sync in UNLOCK has no effect.
- phase_sync and a valid write in the same cycle: write behaviour applies.
- Reset has priority over everything else.

## Timing
- Reset values: acc=0, ce=0, locked=0, lock counter=0, state=UNLOCK, inc=INC_INIT (clamped).
- locked rises on the LOCK_CYC-th edge after reset falls. Lock counter counts 0..LOCK_CYC−1 on consecutive edges.
- Accumulation starts on the first edge with locked=1.
- All outputs are registered. ce[i] reflects the carry of the same edge's addition, with no added pipeline latency.
- inc=2^(ACC_W−1): ce pattern 0,1,0,1… starting at the first RUN edge.
- A write during UNLOCK restarts the count; locked rises LOCK_CYC edges after the last valid write.
- Reset asserted mid-RUN: outputs are at reset values on the next edge.

## Configuration
- Macro CLK_EN_GEN_RECONFIG_EN.
- Defined: the cfg_* write path is active as described above.
- Undefined: inc is fixed at INC_INIT; cfg_we, cfg_ch and cfg_inc are ignored; the FSM leaves UNLOCK only after reset. phase_sync is still supported.

## Test plan
- Default params, release reset → locked=1 at edge 16. Then ch2 ce is constant 1, ch0 toggles starting 0,1, and ch1 pulses once every 8 cycles, first pulse at the 8th RUN edge.
- Write cfg_ch=1, cfg_inc=21845 in RUN → locked=0 next edge and relocks after 16 edges. Over the following 3×65536 cycles ch1 produces exactly 65535 pulses.
- Write cfg_ch=3 (NUM_CH=3) → locked stays 1; ce sequence is unchanged.
- phase_sync in RUN → all ce 0 on that edge; ch0 resumes 0,1 and ch1 pulses 8 edges later; locked stays 1.
- Write cfg_inc=17'h1FFFF → clamped to 65536, ce constantly 1 after relock. Write 0 → ce constantly 0.
- Reset asserted mid-RUN for 1 cycle → ce=0 and locked=0 on the next edge; relock after 16 edges. Repeat the build without CLK_EN_GEN_RECONFIG_EN → writes have no effect.

Source files
------------

// File: rtl/clk_en_gen.sv
// Multi-channel fractional clock-enable generator: one phase accumulator per channel,
// lock FSM gating the enables. Define CLK_EN_GEN_RECONFIG_EN to enable runtime increment writes.
module clk_en_gen #(
    parameter int NUM_CH   = 3,
    parameter int ACC_W    = 16,
    parameter int LOCK_CYC = 16,
    parameter logic [NUM_CH*(ACC_W+1)-1:0] INC_INIT = {17'd65536, 17'd8192, 17'd32768}
) (
    input  logic                                         clk_sys,
    input  logic                                         reset,
    input  logic                                         cfg_we,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
    input  logic [ACC_W:0]                               cfg_inc,
    input  logic                                         phase_sync,
    output logic [NUM_CH-1:0]                            ce,
    output logic                                         locked
);

    localparam logic [ACC_W:0] INC_MAX  = {1'b1, {ACC_W{1'b0}}};
    localparam logic [15:0]    CNT_LAST = 16'(LOCK_CYC - 1);

    typedef enum logic {
        UNLOCK = 1'b0,
        RUN    = 1'b1
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] cnt_reg, cnt_next;
    logic        wr_valid;

    function automatic logic [ACC_W:0] clamp_inc(input logic [ACC_W:0] v);
        return (v > INC_MAX) ? INC_MAX : v;
    endfunction

`ifdef CLK_EN_GEN_RECONFIG_EN
    assign wr_valid = cfg_we && (32'(cfg_ch) < NUM_CH);
`else
    // Fixed-rate build: the write port exists but is never honoured.
    assign wr_valid = 1'b0;
    wire unused_cfg = ^{cfg_we, cfg_ch, cfg_inc};
`endif

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_reg <= UNLOCK;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (wr_valid) begin
            state_next = UNLOCK;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                UNLOCK: begin
                    if (cnt_reg == CNT_LAST) begin
                        state_next = RUN;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + 16'd1;
                    end
                end
                RUN:     state_next = RUN;
                default: state_next = UNLOCK;
            endcase
        end
    end

    assign locked = (state_reg == RUN);

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [ACC_W:0]   inc_reg;
            logic [ACC_W-1:0] acc_reg;
            logic             ce_reg;
            logic [ACC_W:0]   sum;

            // The carry out of the accumulator is the enable for this edge.
            assign sum = {1'b0, acc_reg} + inc_reg;

            always_ff @(posedge clk_sys) begin
                if (reset) begin
                    inc_reg <= clamp_inc(INC_INIT[gi*(ACC_W+1) +: ACC_W+1]);
                    acc_reg <= '0;
                    ce_reg  <= 1'b0;
                end else if (wr_valid) begin
                    if (32'(cfg_ch) == gi) begin
                        inc_reg <= clamp_inc(cfg_inc);
                    end
                    acc_reg <= '0;
                    ce_reg  <= 1'b0;
                end else if (state_reg == UNLOCK || phase_sync) begin
                    acc_reg <= '0;
                    ce_reg  <= 1'b0;
                end else begin
                    acc_reg <= sum[ACC_W-1:0];
                    ce_reg  <= sum[ACC_W];
                end
            end

            assign ce[gi] = ce_reg;
        end
    endgenerate

endmodule

// File: tb/tb_clk_en_gen.sv
// Bench for clk_en_gen: an arithmetic rate model checked every cycle plus directed literal checks.
module tb_clk_en_gen;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_ch = 2'd0;
    logic [16:0] cfg_inc = 17'd0;
    logic        phase_sync = 1'b0;
    logic [2:0]  ce;
    logic        locked;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    clk_en_gen dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_inc    (cfg_inc),
        .phase_sync (phase_sync),
        .ce         (ce),
        .locked     (locked)
    );

    always #5 clk_sys = ~clk_sys;

    // Model: after n RUN edges from alignment, a channel has emitted floor(n*inc/65536) pulses.
    longint   m_inc [3] = '{32768, 8192, 65536};
    longint   m_n   [3] = '{0, 0, 0};
    int       m_since = 0;
    logic     m_locked = 1'b0;
    logic [2:0] m_ce = 3'b000;
    logic     m_wr;

    always @(posedge clk_sys) begin
`ifdef CLK_EN_GEN_RECONFIG_EN
        m_wr = cfg_we && (cfg_ch < 2'd3);
`else
        m_wr = 1'b0;
`endif
        if (reset) begin
            m_inc    = '{32768, 8192, 65536};
            m_n      = '{0, 0, 0};
            m_since  = 0;
            m_locked = 1'b0;
            m_ce     = 3'b000;
        end else if (m_wr) begin
            m_inc[cfg_ch] = (cfg_inc > 17'd65536) ? 65536 : longint'(cfg_inc);
            m_n      = '{0, 0, 0};
            m_since  = 0;
            m_locked = 1'b0;
            m_ce     = 3'b000;
        end else if (!m_locked) begin
            m_since++;
            if (m_since >= 16) m_locked = 1'b1;
            m_ce = 3'b000;
        end else if (phase_sync) begin
            m_n  = '{0, 0, 0};
            m_ce = 3'b000;
        end else begin
            for (int i = 0; i < 3; i++) begin
                m_n[i]++;
                m_ce[i] = (((m_n[i] * m_inc[i]) >> 16) != (((m_n[i] - 1) * m_inc[i]) >> 16));
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk_sys) begin
        if (chk_en) begin
            check("model_ce", 32'(ce), 32'(m_ce));
            check("model_locked", 32'(locked), 32'(m_locked));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic do_write(input logic [1:0] ch, input logic [16:0] inc, input logic sync);
        $display("[TB] write ch=%0d inc=%0d sync=%0d", ch, inc, sync);
        cfg_we     = 1'b1;
        cfg_ch     = ch;
        cfg_inc    = inc;
        phase_sync = sync;
        step(1);
        cfg_we     = 1'b0;
        phase_sync = 1'b0;
    endtask

    int pulses;

    initial begin
        step(2);
        $display("[TB] reset held");
        check("reset_locked", 32'(locked), 32'd0);
        check("reset_ce", 32'(ce), 32'd0);
        chk_en = 1'b1;
        reset  = 1'b0;
        $display("[TB] reset released");
        step(15);
        check("unlocked_edge15", 32'(locked), 32'd0);
        step(1);
        check("locked_edge16", 32'(locked), 32'd1);
        step(1);
        check("ce_first_run", 32'(ce), 32'h4);
        step(1);
        check("ce_second_run", 32'(ce), 32'h5);
        step(6);
        check("ce_eighth_run", 32'(ce), 32'h7);

        do_write(2'd3, 17'd0, 1'b0);
        check("bad_ch_locked", 32'(locked), 32'd1);
        step(3);

        $display("[TB] phase_sync in RUN");
        phase_sync = 1'b1;
        step(1);
        phase_sync = 1'b0;
        check("sync_ce", 32'(ce), 32'd0);
        check("sync_locked", 32'(locked), 32'd1);
        step(1);
        check("sync_ce_p1", 32'(ce), 32'h4);
        step(1);
        check("sync_ce_p2", 32'(ce), 32'h5);
        step(6);
        check("sync_ce_p8", 32'(ce), 32'h7);

`ifdef CLK_EN_GEN_RECONFIG_EN
        do_write(2'd1, 17'd21845, 1'b0);
        check("wr_unlock", 32'(locked), 32'd0);
        step(15);
        check("wr_still_unlocked", 32'(locked), 32'd0);
        step(1);
        check("wr_relocked", 32'(locked), 32'd1);
        pulses = 0;
        repeat (12288) begin
            step(1);
            pulses += int'(ce[1]);
        end
        check("ch1_pulse_count", 32'(pulses), 32'd4095);

        do_write(2'd0, 17'h1FFFF, 1'b0);
        step(16);
        check("clamp_relocked", 32'(locked), 32'd1);
        step(1);
        check("clamp_ce0", 32'(ce[0]), 32'd1);
        step(3);
        check("clamp_ce0_later", 32'(ce[0]), 32'd1);

        do_write(2'd0, 17'd0, 1'b1);
        check("wr_sync_unlock", 32'(locked), 32'd0);
        step(5);
        do_write(2'd2, 17'd65536, 1'b0);
        step(5);
        $display("[TB] phase_sync in UNLOCK");
        phase_sync = 1'b1;
        step(1);
        phase_sync = 1'b0;
        step(9);
        check("restart_unlocked", 32'(locked), 32'd0);
        step(1);
        check("restart_locked", 32'(locked), 32'd1);
        step(4);
        check("zero_inc_ce", 32'(ce), 32'h6);
`else
        do_write(2'd1, 17'd0, 1'b0);
        check("fixed_wr_locked", 32'(locked), 32'd1);
        step(8);
`endif

        $display("[TB] reset pulse in RUN");
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("midrst_locked", 32'(locked), 32'd0);
        check("midrst_ce", 32'(ce), 32'd0);
        step(15);
        check("midrst_unlocked", 32'(locked), 32'd0);
        step(1);
        check("midrst_relocked", 32'(locked), 32'd1);
        step(1);
        check("midrst_ce_run", 32'(ce), 32'h4);
        step(4);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
